// File: rtl/counter_top.sv
// counter_top: start-triggered up-counter with one-cycle done strobe; `COUNTER_RESTART_EN enables restart outside IDLE
module counter_top #(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cnt_val_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] target, tgt_nxt, cnt_nxt;
  logic take;
`ifdef COUNTER_RESTART_EN
  assign take = start_i;
`else
  assign take = start_i && state == IDLE;
`endif
  // next state, count and target; an accepted start overrides the normal flow
  always_comb begin
    nxt = state;
    tgt_nxt = target;
    cnt_nxt = cnt_o;
    case (state)
      IDLE: cnt_nxt = '0;
      RUN: begin
        cnt_nxt = cnt_o + 1'b1;
        nxt = cnt_o == target - 1'b1 ? DONE : RUN;
      end
      DONE: begin
        nxt = IDLE;
        cnt_nxt = '0;
      end
      default: begin
        nxt = IDLE;
        cnt_nxt = '0;
      end
    endcase
    if (take) begin
      cnt_nxt = '0;
      nxt = |cnt_val_i ? RUN : DONE;
      tgt_nxt = |cnt_val_i ? cnt_val_i : target;
    end
  end
  // state, count and target registers; done is registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      target <= '0;
      cnt_o <= '0;
      done_o <= 1'b0;
    end else begin
      state <= nxt;
      target <= tgt_nxt;
      cnt_o <= cnt_nxt;
      done_o <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_counter_top.sv
// tb_counter_top: scoreboard bench for counter_top
module tb_counter_top;
  localparam int W = 7;
  typedef struct packed {
    logic [W-1:0] cnt;
    logic         done;
  } exp_t;
  logic clk, rst, start_i, done_o;
  logic [W-1:0] cnt_val_i, cnt_o;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int passes = 0;

  counter_top #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cnt_val_i(cnt_val_i),
    .cnt_o(cnt_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected samples after edges E0..E(n+1) of a run to n started at E0
  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) sb.push_back(exp_t'{cnt: W'(i), done: 1'b0});
    sb.push_back(exp_t'{cnt: W'(n), done: 1'b1});
    sb.push_back(exp_t'{cnt: '0, done: 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_i = 1'b0;
    cnt_val_i = '0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cnt_o !== '0 || done_o !== 1'b0)
      $display("FAIL reset: cnt_o=%0d done_o=%b expected 0/0", cnt_o, done_o);
    else passes++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (cnt_o !== '0 || done_o !== 1'b0)
        $display("FAIL reset_idle: cnt_o=%0d done_o=%b expected 0/0", cnt_o, done_o);
      else passes++;
    end
  endtask

  task automatic test_run50();
    start_i = 1'b1;
    cnt_val_i = W'(50);
    push_seq(50);
    repeat (240) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL run50: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
  endtask

  task automatic test_zero();
    start_i = 1'b1;
    cnt_val_i = '0;
    push_seq(0);
    repeat (4) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL zero: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
  endtask

  task automatic test_max();
    start_i = 1'b1;
    cnt_val_i = W'(127);
    push_seq(127);
    repeat (133) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL max127: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
  endtask

  task automatic test_restart();
    start_i = 1'b1;
    cnt_val_i = W'(50);
    push_seq(50);
    repeat (21) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL restart_pre: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
    start_i = 1'b1;
    cnt_val_i = W'(5);
`ifdef COUNTER_RESTART_EN
    sb.delete();
    push_seq(5);
`endif
    repeat (40) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL restart: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    start_i = 1'b1;
    cnt_val_i = W'(50);
    push_seq(50);
    repeat (31) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL async_pre: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cnt_o !== '0 || done_o !== 1'b0)
      $display("FAIL async_reset: cnt_o=%0d done_o=%b expected 0/0", cnt_o, done_o);
    else passes++;
    #1 rst = 1'b0;
    sb.delete();
    repeat (60) begin
      @(posedge clk); #1;
      checks++;
      if (cnt_o !== '0 || done_o !== 1'b0)
        $display("FAIL async_quiet: cnt_o=%0d done_o=%b expected 0/0", cnt_o, done_o);
      else passes++;
    end
    start_i = 1'b1;
    cnt_val_i = W'(2);
    push_seq(2);
    repeat (6) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL async_after: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    start_i = 1'b1;
    cnt_val_i = W'(3);
    push_seq(3);
    repeat (5) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      pulses += int'(done_o);
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL b2b_first: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
    start_i = 1'b1;
    cnt_val_i = W'(4);
    push_seq(4);
    repeat (9) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt_val_i = '0;
      pulses += int'(done_o);
      e = sb.size() != 0 ? sb.pop_front() : exp_t'{cnt: '0, done: 1'b0};
      checks++;
      if (cnt_o !== e.cnt || done_o !== e.done)
        $display("FAIL b2b_second: cnt_o=%0d done_o=%b expected %0d/%b", cnt_o, done_o, e.cnt, e.done);
      else passes++;
    end
    checks++;
    if (pulses != 2)
      $display("FAIL b2b_pulses: counted %0d done pulses expected 2", pulses);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_run50();
    test_zero();
    test_max();
    test_restart();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/counter_top.md
# counter_top

Start-triggered up-counter controlled by a small FSM. A one-cycle `start_i` pulse latches a terminal value from `cnt_val_i`. The block then counts `cnt_o` from 0 up to that value, one step per clock, and raises `done_o` for exactly one cycle when it gets there. It serves as a generic programmable delay or sequencing timer inside a larger control path.

## Interface
- `CNT_WIDTH`, default 7: width of `cnt_val_i` and `cnt_o`; legal range 2..32.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start_i`, input, 1: start request, sampled on the rising edge; a one-cycle pulse is sufficient.
- `cnt_val_i`, input, CNT_WIDTH: terminal count; valid only in the cycle `start_i`=1.
- `cnt_o`, output, CNT_WIDTH: current count value (registered).
- `done_o`, output, 1: completion strobe (registered, Moore output of DONE).

## Operation
- FSM states: IDLE, RUN, DONE. Internal register `target` (CNT_WIDTH bits) holds the latched `cnt_val_i`.
- **IDLE**
  - Outputs: `cnt_o`=0, `done_o`=0.
  - If `start_i`=1 and `cnt_val_i`≠0: latch `target`=`cnt_val_i`, go to RUN, `cnt_o`=0.
  - If `start_i`=1 and `cnt_val_i`=0: go directly to DONE, `cnt_o`=0.
- **RUN**
  - Each edge: `cnt_o`←`cnt_o`+1.
  - On the edge where `cnt_o`=`target`−1: `cnt_o`←`target` and go to DONE.
  - `cnt_val_i` is ignored while in RUN.
- **DONE**
  - `done_o`=1 and `cnt_o` holds `target` for exactly one cycle.
  - Next edge: go to IDLE and clear `cnt_o`←0.
- `start_i` in RUN or DONE is ignored, except as described under Configuration.
- Arithmetic is unsigned. `cnt_o` never exceeds `target`, so there is no wrap-around. `target`=2^CNT_WIDTH−1 is legal.

## Timing
- Reset asserted (asynchronously): state=IDLE, `cnt_o`=0, `done_o`=0, `target`=0. This applies immediately and also mid-count; any count in progress is aborted.
- Start sampled at edge E0 with value N>0:
  - Edges E0..EN: `cnt_o`=0..N.
  - `done_o`=1 during the cycle after EN.
  - E(N+1): back in IDLE with `cnt_o`=0.
- Start sampled at edge E0 with value 0: `done_o`=1 during the cycle after E0; E1 returns to IDLE.
- Total start-to-done latency is N+1 edges; `done_o` lasts exactly one clock.
- The earliest accepted restart is the first edge spent in IDLE after DONE, i.e. E(N+2) for a start at E0.

## Configuration
- Macro: `COUNTER_RESTART_EN`.
- **Defined:** `start_i`=1 in RUN or DONE is accepted.
  - The block re-latches `target`=`cnt_val_i` and restarts at `cnt_o`=0 in RUN, or enters DONE if `cnt_val_i`=0.
  - A restart in DONE takes precedence over the return to IDLE; `done_o` is still asserted for that DONE cycle.
- **Undefined:** `start_i` outside IDLE is ignored, as in Operation.

## Test plan
- Reset, then pulse `start_i` with `cnt_val_i`=50 for one cycle, then hold `cnt_val_i`=0 for 240 cycles:
  - `cnt_o` steps 0→50 on consecutive edges.
  - `done_o`=1 for one cycle while `cnt_o`=50.
  - `cnt_o` returns to 0; no further activity.
- Start with `cnt_val_i`=0: `done_o`=1 on the cycle after the start edge; `cnt_o` stays 0; IDLE follows.
- Start with `cnt_val_i`=127 (CNT_WIDTH=7): `cnt_o` reaches 127 without wrapping; `done_o` appears 128 edges after start.
- Pulse `start_i` again (`cnt_val_i`=5) while `cnt_o`=20 of a run to 50:
  - Undefined macro: ignored; the run completes at 50.
  - `COUNTER_RESTART_EN` defined: `cnt_o` restarts at 0 and completes at 5.
- Assert `rst` asynchronously mid-run at `cnt_o`=30: `cnt_o`=0 and `done_o`=0 immediately; no `done_o` follows; a new start works normally.
- Back-to-back runs of 3 then 4, with each start at the first IDLE edge: two separate `done_o` pulses, each lasting one cycle, with correct counts.
